// File: rtl/store_buf.sv
// Store buffer between the load/store unit and memory: a FIFO of pending stores drained over a
// write req/ack handshake, store-to-load forwarding, and a sticky drain-error register.
module store_buf #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         st_valid,
    output logic                         st_ready,
    input  logic [ADDR_WIDTH-1:0]        st_addr,
    input  logic [DATA_WIDTH-1:0]        st_data,
    input  logic                         ld_valid,
    output logic                         ld_ready,
    input  logic [ADDR_WIDTH-1:0]        ld_addr,
    output logic                         ld_rvalid,
    output logic [DATA_WIDTH-1:0]        ld_rdata,
    output logic                         ld_fwd,
    output logic                         mem_wreq,
    output logic [ADDR_WIDTH-1:0]        mem_waddr,
    output logic [DATA_WIDTH-1:0]        mem_wdata,
    input  logic                         mem_wack,
    input  logic                         mem_perr,
    output logic                         mem_rreq,
    output logic [ADDR_WIDTH-1:0]        mem_raddr,
    input  logic [DATA_WIDTH-1:0]        mem_rdata,
    input  logic                         mem_rack,
    output logic                         err_valid,
    output logic [ADDR_WIDTH-1:0]        err_addr,
    input  logic                         err_clr,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];

    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [1:0]            state_q, state_d;
    logic                  err_valid_q, err_valid_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    logic                  hit_q, hit_d;
    logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;
    logic                  rreq_q, rreq_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic                  rd_pend_q, rd_pend_d;

    logic                  enq, ret, ld_acc, match;
    logic [DATA_WIDTH-1:0] match_data;
    logic [PW-1:0]         idx;

    always_comb begin
        enq    = st_valid && (cnt_q < FULL);
        ret    = (state_q == S_WAIT) && mem_wack;
        ld_acc = ld_valid && !rd_pend_q;

        // Scan oldest to youngest over registered entries so the last match wins;
        // a store enqueued this cycle is not yet visible, a retiring head still is.
        match      = 1'b0;
        match_data = '0;
        idx        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((CW'(i) < cnt_q) && (addr_q[idx] == ld_addr)) begin
                match      = 1'b1;
                match_data = data_q[idx];
            end
        end

        addr_d = addr_q;
        data_d = data_q;
        if (enq) begin
            addr_d[tail_q] = st_addr;
            data_d[tail_q] = st_data;
        end
        tail_d = enq ? tail_q + PW'(1) : tail_q;
        head_d = ret ? head_q + PW'(1) : head_q;
        cnt_d  = cnt_q + CW'(enq) - CW'(ret);

        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cnt_q != '0) state_d = S_REQ;
            S_REQ:   state_d = S_WAIT;
            S_WAIT:  if (mem_wack) state_d = (cnt_d != '0) ? S_REQ : S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A new error in the same cycle as a clear wins and reloads the address.
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        if (err_clr) err_valid_d = 1'b0;
        if (ret && mem_perr) begin
            err_valid_d = 1'b1;
            if (!err_valid_q || err_clr) err_addr_d = addr_q[head_q];
        end

        hit_d      = ld_acc && match;
        fwd_data_d = hit_d ? match_data : '0;
        rreq_d     = ld_acc && !match;
        raddr_d    = rreq_d ? ld_addr : raddr_q;
        rd_pend_d  = rreq_d || (rd_pend_q && !mem_rack);
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= '0;
            state_q     <= S_IDLE;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
            hit_q       <= 1'b0;
            fwd_data_q  <= '0;
            rreq_q      <= 1'b0;
            raddr_q     <= '0;
            rd_pend_q   <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
            hit_q       <= hit_d;
            fwd_data_q  <= fwd_data_d;
            rreq_q      <= rreq_d;
            raddr_q     <= raddr_d;
            rd_pend_q   <= rd_pend_d;
        end
    end

    always_comb begin
        st_ready  = cnt_q < FULL;
        ld_ready  = !rd_pend_q;
        count     = cnt_q;
        mem_wreq  = (state_q == S_REQ);
        mem_waddr = mem_wreq ? addr_q[head_q] : '0;
        mem_wdata = mem_wreq ? data_q[head_q] : '0;
        mem_rreq  = rreq_q;
        mem_raddr = raddr_q;
        err_valid = err_valid_q;
        err_addr  = err_addr_q;
        ld_fwd    = hit_q;
        ld_rvalid = hit_q || (rd_pend_q && mem_rack);
        ld_rdata  = '0;
        if (hit_q)                       ld_rdata = fwd_data_q;
        else if (rd_pend_q && mem_rack)  ld_rdata = mem_rdata;
    end

endmodule

// File: tb/tb_store_buf.sv
// Bench for store_buf: directed scenarios plus random traffic, checked every cycle against a
// queue-based model of buffered stores, a reactive memory model, and the error register rules.
module tb_store_buf;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st_valid = 1'b0, st_ready;
    logic [15:0] st_addr = '0, st_data = '0;
    logic        ld_valid = 1'b0, ld_ready;
    logic [15:0] ld_addr = '0;
    logic        ld_rvalid, ld_fwd;
    logic [15:0] ld_rdata;
    logic        mem_wreq;
    logic [15:0] mem_waddr, mem_wdata;
    logic        mem_wack = 1'b0, mem_perr = 1'b0;
    logic        mem_rreq;
    logic [15:0] mem_raddr;
    logic [15:0] mem_rdata = '0;
    logic        mem_rack = 1'b0;
    logic        err_valid;
    logic [15:0] err_addr;
    logic        err_clr = 1'b0;
    logic [2:0]  count;

    always #5 clk = ~clk;

    store_buf dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_fwd(ld_fwd),
        .mem_wreq(mem_wreq), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_wack(mem_wack), .mem_perr(mem_perr),
        .mem_rreq(mem_rreq), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_rack(mem_rack),
        .err_valid(err_valid), .err_addr(err_addr), .err_clr(err_clr), .count(count)
    );

    typedef struct { logic [15:0] a; logic [15:0] d; } st_t;
    st_t q[$];

    int n_tests = 0, n_fail = 0;

    // model / memory-side knobs and state
    bit          stall = 0, perr_all = 0, perr_rand = 0, clr_rand = 0, clr_on_ack = 0;
    bit          force_rd = 0;
    logic [15:0] force_val = '0, rd_val = '0;
    bit          wack_pend = 0, rack_next = 0, rd_pend = 0, wr_busy = 0, exp_wreq = 0;
    bit          exp_hit = 0, exp_rreq = 0, m_err = 0;
    logic [15:0] exp_hdata = '0, exp_raddr = '0, m_eaddr = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        int sz0;
        bit retire, hit;
        logic [15:0] hd;
        mem_wack  = wack_pend && !stall && !rst;
        mem_perr  = mem_wack && (perr_all || (perr_rand && $urandom_range(0, 3) == 0));
        mem_rack  = rack_next;
        rd_val    = force_rd ? force_val : 16'($urandom);
        mem_rdata = rd_val;
        err_clr   = clr_rand ? ($urandom_range(0, 7) == 0) : (clr_on_ack && mem_wack);
        @(negedge clk);
        if (rst) begin
            q.delete();
            wack_pend = 0; rack_next = 0; rd_pend = 0; wr_busy = 0; exp_wreq = 0;
            exp_hit = 0; exp_rreq = 0; m_err = 0;
        end else begin
            chk("count", 32'(count), 32'(q.size()));
            chk("st_ready", 32'(st_ready), 32'(q.size() < 4));
            chk("ld_ready", 32'(ld_ready), 32'(!rd_pend));
            chk("mem_wreq", 32'(mem_wreq), 32'(exp_wreq));
            if (exp_wreq && q.size() > 0) begin
                chk("mem_waddr", 32'(mem_waddr), 32'(q[0].a));
                chk("mem_wdata", 32'(mem_wdata), 32'(q[0].d));
            end
            chk("err_valid", 32'(err_valid), 32'(m_err));
            if (m_err) chk("err_addr", 32'(err_addr), 32'(m_eaddr));
            chk("ld_rvalid", 32'(ld_rvalid), 32'(exp_hit || (rd_pend && mem_rack)));
            if (exp_hit) begin
                chk("ld_fwd_hit", 32'(ld_fwd), 32'd1);
                chk("ld_rdata_hit", 32'(ld_rdata), 32'(exp_hdata));
            end else if (rd_pend && mem_rack) begin
                chk("ld_fwd_miss", 32'(ld_fwd), 32'd0);
                chk("ld_rdata_miss", 32'(ld_rdata), 32'(rd_val));
            end
            chk("mem_rreq", 32'(mem_rreq), 32'(exp_rreq));
            if (exp_rreq) chk("mem_raddr", 32'(mem_raddr), 32'(exp_raddr));

            // state committed at the coming edge
            sz0    = q.size();
            retire = mem_wack && sz0 > 0;
            if (mem_wreq) wack_pend = 1; else if (mem_wack) wack_pend = 0;
            rack_next = mem_rreq;
            if (err_clr) m_err = 0;
            if (retire && mem_perr) begin
                if (!err_valid || err_clr) m_eaddr = q[0].a;
                m_err = 1;
            end
            if (rd_pend && mem_rack) rd_pend = 0;
            exp_hit = 0; exp_rreq = 0;
            if (ld_valid && ld_ready) begin
                hit = 0; hd = '0;
                foreach (q[i]) if (q[i].a == ld_addr) begin hit = 1; hd = q[i].d; end
                if (hit) begin exp_hit = 1; exp_hdata = hd; end
                else begin exp_rreq = 1; exp_raddr = ld_addr; rd_pend = 1; end
            end
            if (retire) void'(q.pop_front());
            if (st_valid && sz0 < 4) q.push_back('{a: st_addr, d: st_data});
            if (exp_wreq) begin wr_busy = 1; exp_wreq = 0; end
            else if (wr_busy) begin
                if (retire) begin wr_busy = 0; exp_wreq = (q.size() > 0); end
            end else exp_wreq = (sz0 > 0);
        end
        @(posedge clk); #1;
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d);
        st_valid = 1; st_addr = a; st_data = d;
        tick();
        st_valid = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1; idle(2); rst = 0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_st_ready", 32'(st_ready), 32'd1);
        chk("rst_ld_ready", 32'(ld_ready), 32'd1);
        chk("rst_err_valid", 32'(err_valid), 32'd0);
        chk("rst_mem_wreq", 32'(mem_wreq), 32'd0);

        // single store drains
        store(16'h0010, 16'hBEEF);
        idle(6);
        chk("t1_count", 32'(count), 32'd0);
        chk("t1_err", 32'(err_valid), 32'd0);

        // fill with drain stalled, then release
        stall = 1;
        for (int i = 0; i < 4; i++) store(16'h0100 + 16'(i), 16'hA000 + 16'(i));
        st_valid = 1; st_addr = 16'h0104; st_data = 16'hA004;
        idle(3);
        chk("t2_full_count", 32'(count), 32'd4);
        chk("t2_full_ready", 32'(st_ready), 32'd0);
        stall = 0;
        idle(2);
        st_valid = 0;
        chk("t2_count_after", 32'(count), 32'd4);
        idle(14);

        // youngest match forwarding
        stall = 1;
        store(16'h0020, 16'h0001);
        store(16'h0020, 16'h0002);
        ld_valid = 1; ld_addr = 16'h0020; tick(); ld_valid = 0;
        chk("t3_fwd", 32'(ld_rvalid && ld_fwd), 32'd1);
        chk("t3_data", 32'(ld_rdata), 32'd2);
        chk("t3_no_rreq", 32'(mem_rreq), 32'd0);
        stall = 0;
        idle(8);

        // load miss goes to memory
        force_rd = 1; force_val = 16'h1234;
        ld_valid = 1; ld_addr = 16'h0030; tick(); ld_valid = 0;
        chk("t4_rreq", 32'(mem_rreq), 32'd1);
        chk("t4_raddr", 32'(mem_raddr), 32'h30);
        idle(4);
        force_rd = 0;

        // sticky error capture; clear coinciding with a new error
        perr_all = 1;
        store(16'h0005, 16'h0);
        store(16'h0006, 16'h0);
        idle(8);
        chk("t5_err_valid", 32'(err_valid), 32'd1);
        chk("t5_err_addr1", 32'(err_addr), 32'h5);
        clr_on_ack = 1;
        store(16'h0007, 16'h0);
        idle(6);
        clr_on_ack = 0; perr_all = 0;
        chk("t5_err_addr2", 32'(err_addr), 32'h7);
        chk("t5_err_valid2", 32'(err_valid), 32'd1);

        // reset mid-operation
        stall = 1;
        store(16'h0040, 16'h1); store(16'h0041, 16'h2); store(16'h0042, 16'h3);
        idle(3);
        rst = 1; tick(); rst = 0; stall = 0;
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_wreq", 32'(mem_wreq), 32'd0);
        chk("t6_st_ready", 32'(st_ready), 32'd1);
        idle(3);

        // random traffic
        perr_rand = 1; clr_rand = 1;
        for (int c = 0; c < 3000; c++) begin
            st_valid = ($urandom_range(0, 1) == 1);
            st_addr  = 16'($urandom_range(0, 7));
            st_data  = 16'($urandom);
            ld_valid = ($urandom_range(0, 2) == 0);
            ld_addr  = 16'($urandom_range(0, 9));
            stall    = ($urandom_range(0, 3) == 0);
            tick();
        end
        st_valid = 0; ld_valid = 0; stall = 0; perr_rand = 0; clr_rand = 0;
        idle(20);
        chk("end_count", 32'(count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
